// File: rtl/dm_rr_arbiter_pkg.sv
// dm_rr_arbiter_pkg: shared FSM encodings and index-width helper for the data-memory arbiter
package dm_rr_arbiter_pkg;
    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} arb_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dm_rr_arbiter_picker.sv
// dm_rr_arbiter_picker: first eligible core at or above ptr, wrapping to 0
module dm_rr_arbiter_picker import dm_rr_arbiter_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] winner
);
    always_comb begin
        found  = 1'b0;
        winner = '0;
        // descending scan so the smallest offset from ptr wins
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr) + k) % N]) begin
                found  = 1'b1;
                winner = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/dm_rr_arbiter.sv
// dm_rr_arbiter: round-robin sharing of single-port MemoryQ among N_CORES cores
module dm_rr_arbiter import dm_rr_arbiter_pkg::*; #(
    parameter int N_CORES   = 4,
    parameter int reg_width = 12,
    parameter int READ_LAT  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           arb_en,
    input  logic [N_CORES-1:0]             req,
    input  logic [N_CORES-1:0]             we,
    input  logic [N_CORES*reg_width-1:0]   addr,
    input  logic [N_CORES*reg_width-1:0]   wdata,
    output logic [N_CORES-1:0]             gnt,
    output logic [N_CORES-1:0]             rvalid,
    output logic [reg_width-1:0]           rdata,
    output logic                           busy,
    output logic [reg_width-1:0]           mem_addr,
    output logic [reg_width-1:0]           mem_data,
    output logic                           mem_wren,
    input  logic [reg_width-1:0]           mem_q
);
    localparam int IW = idx_w(N_CORES);

    arb_state_t          state, nxt;
    logic                en_grant, found;
    logic [IW-1:0]       ptr, win, gidx;
    logic [N_CORES-1:0]  inflight, eligible;
    logic [READ_LAT-1:0] pv;
    logic [IW-1:0]       pc [READ_LAT];

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else state <= nxt;
    end

    always_comb begin
        nxt = (state == ST_RUN) ? (arb_en ? ST_RUN : ST_DRAIN) : (arb_en ? ST_RUN : ST_DRAIN);
    end

    // leaving DRAIN grants at the same edge that sees arb_en return
    always_comb begin
        en_grant = (nxt == ST_RUN);
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < READ_LAT; k++)
            if (pv[k]) inflight = inflight | (N_CORES'(1) << pc[k]);
        eligible = req & ~gnt & ~inflight;
    end

    dm_rr_arbiter_picker #(.N(N_CORES), .IW(IW)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (found),
        .winner   (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt      <= '0;
            gidx     <= '0;
            ptr      <= '0;
            mem_wren <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            pv       <= '0;
        end else begin
            if (en_grant && found) begin
                gnt      <= N_CORES'(1) << win;
                gidx     <= win;
                mem_addr <= addr[win*reg_width +: reg_width];
                mem_data <= wdata[win*reg_width +: reg_width];
                mem_wren <= we[win];
                ptr      <= (win == IW'(N_CORES - 1)) ? '0 : win + 1'b1;
            end else begin
                gnt      <= '0;
                mem_wren <= 1'b0;
            end
            pv <= READ_LAT'({pv, |gnt & ~mem_wren});
        end
    end

    // core indices ride alongside the valid bits; validity alone is reset
    always_ff @(posedge clk) begin
        pc[0] <= gidx;
        for (int k = 1; k < READ_LAT; k++) pc[k] <= pc[k-1];
    end

    always_comb begin
        rvalid = pv[READ_LAT-1] ? (N_CORES'(1) << pc[READ_LAT-1]) : '0;
        rdata  = mem_q;
        busy   = |gnt | |pv;
    end
endmodule

// File: tb/tb_dm_rr_arbiter.sv
// tb_dm_rr_arbiter: directed scoreboard bench with a 2-cycle MemoryQ model
module tb_dm_rr_arbiter;
    localparam int N = 4;
    localparam int W = 12;

    typedef struct {logic [N-1:0] g; logic w; logic [W-1:0] a; logic [W-1:0] d;} gexp_t;
    typedef struct {logic [N-1:0] v; logic [W-1:0] q;} rexp_t;

    logic clk = 1'b0, reset = 1'b1, arb_en = 1'b1;
    logic [N-1:0] req = '0, we = '0;
    logic [N*W-1:0] addr = '0, wdata = '0;
    logic [N-1:0] gnt, rvalid;
    logic [W-1:0] rdata, mem_addr, mem_data, mem_q, s1;
    logic busy, mem_wren;

    logic [W-1:0] wm [4096];
    logic [4095:0] wv;

    gexp_t exp_g[$];
    rexp_t exp_r[$];
    int lat_q[$];
    int cnt[N];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_idle = 0, final_chk = 0;
    int exp_busy = -1;

    always #5 clk = ~clk;

    dm_rr_arbiter #(.N_CORES(N), .reg_width(W), .READ_LAT(2)) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    function automatic logic [W-1:0] pre(input logic [W-1:0] a);
        return (a == 12'h005) ? 12'h0A3 : (a ^ 12'hC00);
    endfunction

    always @(posedge clk) begin
        if (reset) wv <= '0;
        else if (mem_wren) begin
            wm[mem_addr] <= mem_data;
            wv[mem_addr] <= 1'b1;
        end
        s1    <= wv[mem_addr] ? wm[mem_addr] : pre(mem_addr);
        mem_q <= s1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    initial begin
        gexp_t e;
        rexp_t r;
        int lat;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) lat_q.delete();
            if (gnt != 0) begin
                if (exp_g.size() == 0) chk("unexpected_gnt", 32'(gnt), 0);
                else begin
                    e = exp_g.pop_front();
                    chk("gnt", 32'(gnt), 32'(e.g));
                    chk("mem_addr", 32'(mem_addr), 32'(e.a));
                    chk("mem_wren", 32'(mem_wren), 32'(e.w));
                    chk("mem_data", 32'(mem_data), 32'(e.d));
                end
                if (!mem_wren) lat_q.push_back(cyc + 2);
            end
            if (rvalid != 0) begin
                if (exp_r.size() == 0) chk("unexpected_rvalid", 32'(rvalid), 0);
                else begin
                    r = exp_r.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(r.v));
                    chk("rdata", 32'(rdata), 32'(r.q));
                end
                lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
                chk("rd_latency", 32'(cyc), 32'(lat));
            end
            if (chk_idle) begin
                chk("idle_gnt", 32'(gnt), 0);
                chk("idle_rvalid", 32'(rvalid), 0);
                chk("idle_wren", 32'(mem_wren), 0);
                chk("idle_busy", 32'(busy), 0);
                chk("idle_addr", 32'(mem_addr), 0);
                chk("idle_data", 32'(mem_data), 0);
            end
            if (exp_busy >= 0) chk("busy", 32'(busy), 32'(exp_busy));
            if (final_chk) chk("pending_exp", 32'(exp_g.size() + exp_r.size()), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_idle = 0;
        exp_busy = -1;
        for (int i = 0; i < N; i++)
            if (gnt[i]) begin
                cnt[i]--;
                if (cnt[i] == 0) req[i] = 1'b0;
            end
    endtask

    task automatic set_req(input int i, input logic w, input logic [W-1:0] a, input logic [W-1:0] d, input int n);
        we[i] = w;
        addr[i*W +: W] = a;
        wdata[i*W +: W] = d;
        cnt[i] = n;
        req[i] = 1'b1;
    endtask

    task automatic pg(input logic [N-1:0] g, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        gexp_t e;
        e.g = g; e.w = w; e.a = a; e.d = d;
        exp_g.push_back(e);
    endtask

    task automatic pr(input logic [N-1:0] v, input logic [W-1:0] q);
        rexp_t r;
        r.v = v; r.q = q;
        exp_r.push_back(r);
    endtask

    initial begin
        // reset held with all cores requesting; core0 will re-request once
        for (int i = 0; i < N; i++) set_req(i, 1'b0, W'(i + 1), '0, (i == 0) ? 2 : 1);
        tick();
        chk_idle = 1;
        tick();
        chk_idle = 1;
        reset = 1'b0;
        pg(4'b0001, 0, 12'h001, 0); pg(4'b0010, 0, 12'h002, 0);
        pg(4'b0100, 0, 12'h003, 0); pg(4'b1000, 0, 12'h004, 0);
        pg(4'b0001, 0, 12'h001, 0);
        pr(4'b0001, 12'hC01); pr(4'b0010, 12'hC02); pr(4'b0100, 12'hC03);
        pr(4'b1000, 12'hC04); pr(4'b0001, 12'hC01);
        repeat (10) tick();

        // single read of a preloaded word
        set_req(1, 1'b0, 12'h005, '0, 1);
        pg(4'b0010, 0, 12'h005, 0);
        pr(4'b0010, 12'h0A3);
        repeat (5) tick();
        exp_busy = 0;
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle = 1;
        tick();

        // write and read of the same address requested together
        set_req(2, 1'b1, 12'h010, 12'h384, 1);
        set_req(3, 1'b0, 12'h010, '0, 1);
        pg(4'b0100, 1, 12'h010, 12'h384);
        pg(4'b1000, 0, 12'h010, 0);
        pr(4'b1000, 12'h384);
        repeat (6) tick();

        // drain: arb_en drops after two reads while core2 waits
        set_req(0, 1'b0, 12'h001, '0, 1);
        set_req(1, 1'b0, 12'h002, '0, 1);
        set_req(2, 1'b0, 12'h003, '0, 1);
        pg(4'b0001, 0, 12'h001, 0); pg(4'b0010, 0, 12'h002, 0);
        pr(4'b0001, 12'hC01); pr(4'b0010, 12'hC02);
        tick();
        tick();
        arb_en = 1'b0;
        tick();
        exp_busy = 1;
        tick();
        tick();
        exp_busy = 0;
        tick();
        exp_busy = 0;
        arb_en = 1'b1;
        pg(4'b0100, 0, 12'h003, 0);
        pr(4'b0100, 12'hC03);
        tick();
        exp_busy = 1;
        repeat (4) tick();

        // reset one cycle after a read grant discards that read
        set_req(1, 1'b0, 12'h005, '0, 1);
        pg(4'b0010, 0, 12'h005, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_idle = 1;
        reset = 1'b0;
        tick();
        chk_idle = 1;
        repeat (4) tick();

        final_chk = 1;
        @(negedge clk);
        #1;
        final_chk = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
